mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and MEM stages onto one single-ported memory with a
// fixed read latency; one access is in flight at a time, round-robin on ties.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

  // Loaded at issue so that zero is reached exactly LATENCY cycles later.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t     state;
  state_t     state_nxt;
  grant_t     last_grant;
  grant_t     last_grant_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       grant_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GRANT_IF;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = if_addr;
    ram_wdata      = mem_wdata;
    if_ready       = 1'b0;
    mem_ready      = 1'b0;
    if_rdata       = ram_rdata;
    mem_rdata      = ram_rdata;
    grant_mem      = mem_req && (!if_req || (last_grant == GRANT_IF));

    case (state)
      IDLE: begin
        if (if_req || mem_req) begin
          ram_en  = 1'b1;
          cnt_nxt = CNT_LOAD;
          if (grant_mem) begin
            ram_we         = mem_we;
            ram_addr       = mem_addr;
            state_nxt      = BUSY_MEM;
            last_grant_nxt = GRANT_MEM;
          end else begin
            state_nxt      = BUSY_IF;
            last_grant_nxt = GRANT_IF;
          end
        end
      end
      BUSY_IF: begin
        if (cnt == 4'd0) begin
          if_ready  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      BUSY_MEM: begin
        if (cnt == 4'd0) begin
          mem_ready = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reset is synchronous, so the registered state may still be busy during
    // the reset cycle; the strobes are masked here to abandon that access.
    if (rst) begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      if_ready  = 1'b0;
      mem_ready = 1'b0;
    end

    stall_if  = if_req & ~if_ready;
    stall_mem = mem_req & ~mem_ready;
  end

endmodule
